// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and policy state encoding for the writeback arbiter
package rf_wb_arbiter_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_state_e;

  typedef logic [REG_W-1:0]  reg_sel_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - requester, decode-read and write-port signals of the writeback arbiter
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic      a_req;
  reg_sel_t  a_sel;
  reg_data_t a_data;
  logic      a_ack;
  logic      b_req;
  reg_sel_t  b_sel;
  reg_data_t b_data;
  logic      b_ack;
  logic      b_kill;
  reg_sel_t  rd1_sel;
  reg_sel_t  rd2_sel;
  logic      write;
  reg_sel_t  writeregsel;
  reg_data_t writedata;
  logic      bypass;
  logic      bypassReg1;
  logic      bypassReg2;
  logic      rf_err;
  logic      err_sticky;

  modport slave (
    input  a_req, a_sel, a_data, b_req, b_sel, b_data, rd1_sel, rd2_sel, rf_err,
    output a_ack, b_ack, b_kill, write, writeregsel, writedata,
           bypass, bypassReg1, bypassReg2, err_sticky
  );

  modport master (
    output a_req, a_sel, a_data, b_req, b_sel, b_data, rd1_sel, rd2_sel, rf_err,
    input  a_ack, b_ack, b_kill, write, writeregsel, writedata,
           bypass, bypassReg1, bypassReg2, err_sticky
  );

endinterface

// File: rtl/rf_wb_arbiter_stage.sv
// rtl/rf_wb_arbiter_stage.sv - registered write stage with bypass compare for one register-file write port
module rf_wb_stage
  import rf_wb_arbiter_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      grant_i,
  input  reg_sel_t  sel_i,
  input  reg_data_t data_i,
  input  reg_sel_t  rd1_sel_i,
  input  reg_sel_t  rd2_sel_i,
  output logic      write_o,
  output reg_sel_t  writeregsel_o,
  output reg_data_t writedata_o,
  output logic      bypass_o,
  output logic      bypass_reg1_o,
  output logic      bypass_reg2_o
);

  logic      write_q;
  reg_sel_t  sel_q;
  reg_data_t data_q;

  // sel/data hold between writes so the port address stays stable when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      write_q <= grant_i;
      if (grant_i) begin
        sel_q  <= sel_i;
        data_q <= data_i;
      end
    end
  end

  assign write_o       = write_q;
  assign writeregsel_o = sel_q;
  assign writedata_o   = data_q;
  assign bypass_o      = write_q;
  assign bypass_reg1_o = write_q && (sel_q == rd1_sel_i);
  assign bypass_reg2_o = write_q && (sel_q == rd2_sel_i);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester write-port arbiter with starvation guard, same-register kill and bypass
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  rf_wb_arbiter_if.slave wb
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  pri_state_e state_q, state_d;
  logic [1:0] starve_q, starve_d;
  logic       a_grant, b_grant, kill, b_ack;
  logic       err_q;
  logic       write_w;
  reg_sel_t   win_sel;
  reg_data_t  win_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PRI_A;
      starve_q <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_q | (wb.rf_err & write_w);
    end
  end

  always_comb begin
    a_grant  = 1'b0;
    b_grant  = 1'b0;
    kill     = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;

    unique case (state_q)
      PRI_A: begin
        a_grant = wb.a_req;
        b_grant = !wb.a_req && wb.b_req;
        // A is program-younger, so an older B to the same register is dropped
        kill    = wb.a_req && wb.b_req && (wb.a_sel == wb.b_sel);
      end
      PRI_B: begin
        b_grant = wb.b_req;
        a_grant = !wb.b_req && wb.a_req;
      end
      default: ;
    endcase

    b_ack = b_grant || kill;

    if (b_ack) begin
      starve_d = 2'd0;
    end else if (wb.b_req && (starve_q != 2'd3)) begin
      starve_d = starve_q + 2'd1;
    end

    // look at the updated count so B wins on the very next cycle
    unique case (state_q)
      PRI_A: if (starve_d >= STARVE_LIM) state_d = PRI_B;
      PRI_B: if (b_ack) state_d = PRI_A;
      default: state_d = PRI_A;
    endcase
  end

  assign win_sel  = a_grant ? wb.a_sel  : wb.b_sel;
  assign win_data = a_grant ? wb.a_data : wb.b_data;

  rf_wb_stage u_stage (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .grant_i       (a_grant || b_grant),
    .sel_i         (win_sel),
    .data_i        (win_data),
    .rd1_sel_i     (wb.rd1_sel),
    .rd2_sel_i     (wb.rd2_sel),
    .write_o       (write_w),
    .writeregsel_o (wb.writeregsel),
    .writedata_o   (wb.writedata),
    .bypass_o      (wb.bypass),
    .bypass_reg1_o (wb.bypassReg1),
    .bypass_reg2_o (wb.bypassReg2)
  );

  assign wb.write      = write_w;
  assign wb.a_ack      = a_grant;
  assign wb.b_ack      = b_ack;
  assign wb.b_kill     = kill;
  assign wb.err_sticky = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  localparam int STARVE_MAX = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  bit   check_en = 1'b0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb     (bus)
  );

  always #5 clk = ~clk;

  // Reference: B has priority once it has been refused STARVE_MAX times since its last ack.
  int          refused, n_refused;
  bit          m_write, m_err, n_grant, n_err;
  logic [2:0]  m_sel, n_sel;
  logic [15:0] m_data, n_data;
  bit          e_a_ack, e_b_ack, e_b_kill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    refused = 0; n_refused = 0;
    m_write = 0; m_err = 0; m_sel = 0; m_data = 0;
    n_grant = 0; n_err = 0; n_sel = 0; n_data = 0;
    e_a_ack = 0; e_b_ack = 0; e_b_kill = 0;
  endtask

  task automatic model_commit();
    m_write = n_grant;
    if (n_grant) begin
      m_sel  = n_sel;
      m_data = n_data;
    end
    m_err   = n_err;
    refused = n_refused;
  endtask

  task automatic model_compute(input bit ar, input logic [2:0] as, input logic [15:0] ad,
                               input bit br, input logic [2:0] bs, input logic [15:0] bd, input bit re);
    bit b_pri, a_win, b_win;
    b_pri    = refused >= STARVE_MAX;
    a_win    = ar && !(b_pri && br);
    b_win    = br && !a_win;
    e_a_ack  = a_win;
    e_b_kill = a_win && br && (as == bs);
    e_b_ack  = b_win || e_b_kill;
    n_grant  = a_win || b_win;
    n_sel    = a_win ? as : bs;
    n_data   = a_win ? ad : bd;
    n_err    = m_err || (re && m_write);
    n_refused = e_b_ack ? 0 : (br ? refused + 1 : refused);
  endtask

  task automatic step(input bit ar, input logic [2:0] as, input logic [15:0] ad,
                      input bit br, input logic [2:0] bs, input logic [15:0] bd,
                      input logic [2:0] r1, input logic [2:0] r2, input bit re);
    @(posedge clk);
    #1;
    model_commit();
    bus.a_req = ar; bus.a_sel = as; bus.a_data = ad;
    bus.b_req = br; bus.b_sel = bs; bus.b_data = bd;
    bus.rd1_sel = r1; bus.rd2_sel = r2; bus.rf_err = re;
    model_compute(ar, as, ad, br, bs, bd, re);
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
    step(0, 0, 16'h0, 0, 0, 16'h0, r1, r2, 0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_ack", 32'(bus.a_ack), 32'(e_a_ack));
      chk("b_ack", 32'(bus.b_ack), 32'(e_b_ack));
      chk("b_kill", 32'(bus.b_kill), 32'(e_b_kill));
      chk("write", 32'(bus.write), 32'(m_write));
      chk("writeregsel", 32'(bus.writeregsel), 32'(m_sel));
      chk("writedata", 32'(bus.writedata), 32'(m_data));
      chk("bypass", 32'(bus.bypass), 32'(m_write));
      chk("bypassReg1", 32'(bus.bypassReg1), 32'(m_write && (m_sel == bus.rd1_sel)));
      chk("bypassReg2", 32'(bus.bypassReg2), 32'(m_write && (m_sel == bus.rd2_sel)));
      chk("err_sticky", 32'(bus.err_sticky), 32'(m_err));
    end
  end

  bit          ap, bp;
  logic [2:0]  as_r, bs_r;
  logic [15:0] ad_r, bd_r;
  bit          exp_b[6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    rst_n = 1'b0;
    bus.a_req = 0; bus.a_sel = 0; bus.a_data = 0;
    bus.b_req = 0; bus.b_sel = 0; bus.b_data = 0;
    bus.rd1_sel = 0; bus.rd2_sel = 0; bus.rf_err = 0;
    model_reset();
    #22 rst_n = 1'b1;
    #1;
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_writedata", 32'(bus.writedata), 32'd0);
    chk("rst_err", 32'(bus.err_sticky), 32'd0);
    chk("rst_bypass", 32'(bus.bypass), 32'd0);
    check_en = 1'b1;

    // A only, with rf_err during the resulting write
    step(1, 3, 16'hBEEF, 0, 0, 16'h0, 0, 0, 0);
    #1 chk("aonly_ack", 32'(bus.a_ack), 32'd1);
    chk("aonly_nowrite", 32'(bus.write), 32'd0);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);
    #1 chk("aonly_write", 32'(bus.write), 32'd1);
    chk("aonly_sel", 32'(bus.writeregsel), 32'd3);
    chk("aonly_data", 32'(bus.writedata), 32'hBEEF);
    idle(0, 0);
    #1 chk("err_set", 32'(bus.err_sticky), 32'd1);

    // starvation: grants go A,A,B,A,A,B
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 16'(16'h100 + i), 1, 2, 16'h0222, 0, 0, 0);
      #1 chk("starve_b_ack", 32'(bus.b_ack), 32'(exp_b[i]));
      chk("starve_a_ack", 32'(bus.a_ack), 32'(!exp_b[i]));
    end
    idle(0, 0);

    // same-register kill in PRI_A
    step(1, 5, 16'h0001, 1, 5, 16'h0002, 0, 0, 0);
    #1 chk("kill_a_ack", 32'(bus.a_ack), 32'd1);
    chk("kill_b_ack", 32'(bus.b_ack), 32'd1);
    chk("kill_b_kill", 32'(bus.b_kill), 32'd1);
    idle(0, 0);
    #1 chk("kill_write", 32'(bus.write), 32'd1);
    chk("kill_sel", 32'(bus.writeregsel), 32'd5);
    chk("kill_data", 32'(bus.writedata), 32'd1);
    idle(0, 0);
    #1 chk("kill_nolater", 32'(bus.write), 32'd0);

    // same register while B has priority: B then A, no kill
    step(1, 0, 16'h00C0, 1, 5, 16'h00B2, 0, 0, 0);
    step(1, 0, 16'h00C1, 1, 5, 16'h00B2, 0, 0, 0);
    step(1, 5, 16'h00A1, 1, 5, 16'h00B2, 0, 0, 0);
    #1 chk("prib_b_ack", 32'(bus.b_ack), 32'd1);
    chk("prib_no_kill", 32'(bus.b_kill), 32'd0);
    chk("prib_a_wait", 32'(bus.a_ack), 32'd0);
    step(1, 5, 16'h00A1, 0, 0, 16'h0, 0, 0, 0);
    #1 chk("prib_w1_data", 32'(bus.writedata), 32'h00B2);
    chk("prib_w1_sel", 32'(bus.writeregsel), 32'd5);
    idle(0, 0);
    #1 chk("prib_w2_data", 32'(bus.writedata), 32'h00A1);
    chk("prib_w2_write", 32'(bus.write), 32'd1);

    // bypass
    step(1, 2, 16'h1234, 0, 0, 16'h0, 2, 4, 0);
    idle(2, 4);
    #1 chk("byp_en", 32'(bus.bypass), 32'd1);
    chk("byp_r1", 32'(bus.bypassReg1), 32'd1);
    chk("byp_r2", 32'(bus.bypassReg2), 32'd0);
    idle(2, 4);
    #1 chk("byp_idle", 32'({bus.bypass, bus.bypassReg1, bus.bypassReg2}), 32'd0);

    // randomized traffic; requests hold until acked
    ap = 0; bp = 0;
    as_r = 0; bs_r = 0; ad_r = 0; bd_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ap || e_a_ack) begin
        ap = ($urandom_range(0, 3) != 0);
        as_r = 3'($urandom_range(0, 3));
        ad_r = 16'($urandom);
      end
      if (!bp || e_b_ack) begin
        bp = ($urandom_range(0, 2) != 0);
        bs_r = 3'($urandom_range(0, 3));
        bd_r = 16'($urandom);
      end
      step(ap, as_r, ad_r, bp, bs_r, bd_r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 31) == 0);
    end
    idle(0, 0);
    idle(0, 0);

    // asynchronous reset while a write is held, with B owed priority
    step(1, 4, 16'h5555, 1, 6, 16'h6666, 4, 4, 0);
    step(1, 4, 16'h5556, 1, 6, 16'h6666, 4, 4, 0);
    idle(4, 4);
    #1 chk("pre_rst_write", 32'(bus.write), 32'd1);
    chk("pre_rst_err", 32'(bus.err_sticky), 32'd1);
    check_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("rst_async_write", 32'(bus.write), 32'd0);
    chk("rst_async_byp", 32'({bus.bypass, bus.bypassReg1, bus.bypassReg2}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    step(1, 1, 16'h0077, 1, 2, 16'h0088, 0, 0, 0);
    check_en = 1'b1;
    #1 chk("post_rst_a_wins", 32'(bus.a_ack), 32'd1);
    chk("post_rst_b_wait", 32'(bus.b_ack), 32'd0);
    chk("post_rst_err", 32'(bus.err_sticky), 32'd0);
    idle(0, 0);
    idle(0, 0);
    @(posedge clk);
    #1;
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
